// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB pipeline stage register with valid/ready handshake,
// optional two-entry skid buffer, synchronous flush and a write-back
// forwarding tap driven from the output slot.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 5,
  parameter int WB_W   = 2,   // bit 0 = RegWrite, bit 1 = MemToReg; must be >= 2
  parameter int SKID   = 1    // 1: two entries, registered in_ready; 0: one slot
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WB_W-1:0]   wb_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] mem_read_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WB_W-1:0]   wb_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] mem_read_out,
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data
);

  // Whole instruction payload carried as one vector; fields are copied bit-exact.
  localparam int PAY_W = WB_W + DEST_W + 2 * DATA_W;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_pay_q, main_pay_d;
  logic [PAY_W-1:0] skid_pay_q, skid_pay_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             accept;
  logic             drain;

  assign in_pay = {wb_in, dest_in, alu_res_in, mem_read_in};
  assign {wb_out, dest_out, alu_res_out, mem_read_out} = main_pay_q;
  assign out_valid = main_valid_q;

  // Ready: straight from the skid flop when buffered, so out_ready never
  // reaches in_ready combinationally; single-slot mode allows pass-through.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = ~skid_valid_q;
    end else begin : g_slot_ready
      assign in_ready = ~main_valid_q | out_ready;
    end
  endgenerate

  assign accept = in_valid & in_ready;
  assign drain  = main_valid_q & out_ready;

  // Next-state for both slots: flush wins, then skid->main refill, then load.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; an unassigned path would infer a latch.
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_pay_d   = main_pay_q;
    skid_pay_d   = skid_pay_q;

    if (flush) begin
      // Only the valid bits clear; a same-cycle drain still completes and
      // any same-cycle input is discarded.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID != 0) begin
      if (drain && skid_valid_q) begin
        // in_ready is low while skid is full, so no accept can coincide.
        main_pay_d   = skid_pay_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        if (!main_valid_q || drain) begin
          main_pay_d   = in_pay;
          main_valid_d = 1'b1;
        end else begin
          skid_pay_d   = in_pay;
          skid_valid_d = 1'b1;
        end
      end else if (drain) begin
        main_valid_d = 1'b0;
      end
    end else begin
      if (accept) begin
        main_pay_d   = in_pay;
        main_valid_d = 1'b1;
      end else if (drain) begin
        main_valid_d = 1'b0;
      end
    end
  end

  // Slot registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: payload flops are reset too, so the outputs read as zero straight
      // after reset instead of X.
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_pay_q   <= '0;
      skid_pay_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge value of the others.
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_pay_q   <= main_pay_d;
      skid_pay_q   <= skid_pay_d;
    end
  end

  // Forwarding tap: live, writing, and not targeting the hardwired zero reg.
  assign fwd_valid = main_valid_q & wb_out[0] & (dest_out != '0);
  assign fwd_dest  = dest_out;
  assign fwd_data  = wb_out[1] ? mem_read_out : alu_res_out;

endmodule
